rv_muldiv_unit: RTL and testbench

Iterative multiply/divide unit implementing all eight RV32IM M-extension operations, generalised to any even XLEN, for the core's execute stage. It decodes func3 and accepts operands over a valid/ready handshake. It computes with a radix-2 shift-add/shift-subtract datapath and holds the result until the consumer takes it. A flush input lets the core kill an in-flight operation on a branch or jump redirect.

---
 rtl/rv_muldiv_pkg.sv | 46 ++++
 rtl/rv_muldiv_step.sv | 29 ++
 rtl/rv_muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_muldiv_pkg.sv
// Shared types for the RV32IM multiply/divide unit: func3 encoding, FSM states,
// latched operation descriptor and the func3 decoder.
package rv_muldiv_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } func3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic is_div;
    logic is_rem;
    logic high_half;
    logic signed_a;
    logic signed_b;
  } op_desc_t;

  // Map func3 onto the operation descriptor latched at issue.
  function automatic op_desc_t decode_op(input logic [2:0] f3);
    op_desc_t d;
    d           = '0;
    d.is_div    = f3[2];
    d.is_rem    = f3[2] & f3[1];
    case (func3_e'(f3))
      F3_MULH:        begin d.high_half = 1'b1; d.signed_a = 1'b1; d.signed_b = 1'b1; end
      F3_MULHSU:      begin d.high_half = 1'b1; d.signed_a = 1'b1; end
      F3_MULHU:       d.high_half = 1'b1;
      F3_DIV, F3_REM: begin d.signed_a = 1'b1; d.signed_b = 1'b1; end
      default:        ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rv_muldiv_step.sv
// One radix-2 iteration on the shared 2*XLEN accumulator: shift-add for multiply
// (multiplier in the low half), restoring shift-subtract for divide.
module rv_muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opd_i,
  output logic [2*XLEN-1:0] acc_c_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] part;
  logic [XLEN:0] diff;

  always_comb begin
    part = acc_i[2*XLEN-1:XLEN-1];
    diff = part - {1'b0, opd_i};
    sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opd_i} : {(XLEN+1){1'b0}});
    if (is_div_i) begin
      // Borrow in the top bit means the divisor did not fit: restore.
      if (!diff[XLEN]) acc_c_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      else             acc_c_o = {part[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
    end else begin
      acc_c_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32IM multiply/divide unit with valid/ready handshake and flush.
// Defining RV_MULDIV_FAST_MUL_EN replaces iterative multiplies with a one-cycle multiplier.
module rv_muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned ACC_W = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  op_desc_t          op_q, op_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [XLEN-1:0]   result_q, result_d;

  op_desc_t          op_in;
  logic              neg_a_in, neg_b_in, div0, ovf;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [ACC_W-1:0]  step_acc, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin_res;

  assign in_ready  = (state_q == IDLE) && !flush && reset;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

  // Issue-side decode, operand magnitudes and special-case detection.
  assign op_in    = decode_op(func3);
  assign neg_a_in = op_in.signed_a & rs1_data[XLEN-1];
  assign neg_b_in = op_in.signed_b & rs2_data[XLEN-1];
  assign mag_a    = neg_a_in ? -rs1_data : rs1_data;
  assign mag_b    = neg_b_in ? -rs2_data : rs2_data;
  assign div0     = op_in.is_div && (rs2_data == '0);
  assign ovf      = op_in.is_div && op_in.signed_a && (rs1_data == MIN_NEG) && (rs2_data == '1);

`ifdef RV_MULDIV_FAST_MUL_EN
  logic [ACC_W-1:0] fast_mag, fast_prod;
  logic [XLEN-1:0]  fast_res;
  assign fast_mag  = ACC_W'(mag_a) * ACC_W'(mag_b);
  assign fast_prod = (neg_a_in ^ neg_b_in) ? -fast_mag : fast_mag;
  assign fast_res  = op_in.high_half ? fast_prod[ACC_W-1:XLEN] : fast_prod[XLEN-1:0];
`endif

  rv_muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_q.is_div),
    .acc_i    (acc_q),
    .opd_i    (opd_q),
    .acc_c_o  (step_acc)
  );

  // Sign fix and result select applied to the final iteration's accumulator.
  always_comb begin
    prod_s = (neg_a_q ^ neg_b_q) ? -step_acc : step_acc;
    quo_s  = (neg_a_q ^ neg_b_q) ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    rem_s  = neg_a_q ? -step_acc[ACC_W-1:XLEN] : step_acc[ACC_W-1:XLEN];
    if (op_q.is_div)         fin_res = op_q.is_rem ? rem_s : quo_s;
    else if (op_q.high_half) fin_res = prod_s[ACC_W-1:XLEN];
    else                     fin_res = prod_s[XLEN-1:0];
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          op_d    = op_in;
          neg_a_d = neg_a_in;
          neg_b_d = neg_b_in;
          count_d = CNT_W'(XLEN - 1);
          if (div0) begin
            result_d = op_in.is_rem ? rs1_data : '1;
            state_d  = DONE;
          end else if (ovf) begin
            result_d = op_in.is_rem ? '0 : rs1_data;
            state_d  = DONE;
`ifdef RV_MULDIV_FAST_MUL_EN
          end else if (!op_in.is_div) begin
            result_d = fast_res;
            state_d  = DONE;
`endif
          end else begin
            acc_d   = op_in.is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            opd_d   = op_in.is_div ? mag_b : mag_a;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        if (count_q == '0) begin
          result_d = fin_res;
          state_d  = DONE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed, table-driven bench for rv_muldiv_unit plus handshake, flush and reset sequences.
module tb_rv_muldiv_unit;

  localparam int XLEN = 32;
  localparam int DIV_LAT = XLEN + 1;
`ifdef RV_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int NV = 20;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      func3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  int checks;
  int failures;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [NV];

  rv_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .func3     (func3),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  // Present an op while in_ready is high; returns #1 after the accepting edge.
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    func3    = f3;
    rs1_data = a;
    rs2_data = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges from the accepting edge (inclusive) until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("wait_done_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int rises;
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    func3     = 3'b000;
    rs1_data  = '0;
    rs2_data  = '0;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{3'b001, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, MUL_LAT};
    vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
    vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT};
    vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT};
    vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14,        DIV_LAT};
    vecs[7]  = '{3'b111, 32'd100,        32'd7,         32'd2,         DIV_LAT};
    vecs[8]  = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'b110, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{3'b000, 32'h1234_5678,  32'h10,        32'h2345_6780, MUL_LAT};
    vecs[13] = '{3'b011, 32'h8000_0000,  32'd4,         32'd2,         MUL_LAT};
    vecs[14] = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT};
    vecs[15] = '{3'b000, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT};
    vecs[16] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT};
    vecs[17] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         DIV_LAT};
    vecs[18] = '{3'b100, 32'h8000_0000,  32'd2,         32'hC000_0000, DIV_LAT};
    vecs[19] = '{3'b111, 32'hFFFF_FFFF,  32'h10,        32'hF,         DIV_LAT};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    reset = 1'b1;
    #1 check("rel_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      start_op(vecs[i].f3, vecs[i].a, vecs[i].b);
      wait_done(lat);
      check($sformatf("v%0d_result", i), result, vecs[i].exp);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      take();
      check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
    end

    // Backpressure in DONE, then back-to-back issue
    start_op(3'b101, 32'd100, 32'd7);
    wait_done(lat);
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp%0d_result", c), result, 32'd14);
      check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
      check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    check("b2b_result_kept", result, 32'd14);
    func3    = 3'b111;
    rs1_data = 32'd100;
    rs2_data = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("b2b_accepted", 32'(busy), 32'd1);
    wait_done(lat);
    check("b2b_result", result, 32'd2);
    check("b2b_latency", 32'(lat), 32'(DIV_LAT));
    take();

    // Flush mid-divide
    start_op(3'b100, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    rises = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    check("flush_no_out_valid", 32'(rises), 32'd0);
    check("flush_in_ready_after", 32'(in_ready), 32'd1);

    // Flush together with in_valid is not accepted
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    func3    = 3'b000;
    @(posedge clk);
    #1 begin flush = 1'b0; in_valid = 1'b0; end
    check("flush_issue_busy", 32'(busy), 32'd0);

    // Flush in DONE drops out_valid and keeps result
    start_op(3'b101, 32'd5, 32'd0);
    wait_done(lat);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_done_out_valid", 32'(out_valid), 32'd0);
    check("flush_done_result", result, 32'hFFFF_FFFF);

    // Reset in the middle of a multiply
    start_op(3'b000, 32'd7, 32'hFFFF_FFFD);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check("mrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("mrst_out_valid", 32'(out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("mrst_rel_in_ready", 32'(in_ready), 32'd1);
    start_op(3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_done(lat);
    check("post_rst_result", result, 32'hFFFF_FFEB);
    check("post_rst_latency", 32'(lat), 32'(MUL_LAT));
    take();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
